// File: rtl/softex_lane_sync.sv
// softex_lane_sync
// Per-operation barrier between softex_ctrl and the SoftEx datapath lanes.
// Accepts one command at a time, launches the enabled lanes with a single
// start pulse, waits until every enabled lane has reported completion and
// then returns one aggregated done pulse. Completion pulses from lanes that
// are not pending raise a sticky error flag. A saturating counter records
// how long the operation took.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | ready for a command; outputs held from the last operation
// LAUNCH | one cycle; start pulse to every lane in the latched mask
// WAIT   | collecting completions until no lane remains pending
// DONE   | one cycle; aggregated done pulse, then back to IDLE

module softex_lane_sync #(
   parameter int NUM_LANES = 4,
   parameter int LEN_WIDTH = 16,
   parameter int OP_WIDTH  = 2,
   parameter int CYC_WIDTH = 32
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 clear_i,

   input  logic                 cmd_valid_i,
   output logic                 cmd_ready_o,
   input  logic [OP_WIDTH-1:0]  cmd_op_i,
   input  logic [LEN_WIDTH-1:0] cmd_len_i,
   input  logic [NUM_LANES-1:0] lane_enable_i,

   output logic [NUM_LANES-1:0] lane_start_o,
   output logic [OP_WIDTH-1:0]  lane_op_o,
   output logic [LEN_WIDTH-1:0] lane_len_o,
   input  logic [NUM_LANES-1:0] lane_done_i,

   output logic                 done_o,
   output logic                 busy_o,
   output logic                 err_o,
   output logic [CYC_WIDTH-1:0] cycles_o
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_LAUNCH = 2'd1,
      ST_WAIT   = 2'd2,
      ST_DONE   = 2'd3
   } state_t;

   state_t               state_q;
   state_t               state_d;

   logic [NUM_LANES-1:0] mask_q;
   logic [NUM_LANES-1:0] pending_q;
   logic [NUM_LANES-1:0] pending_d;
   logic [OP_WIDTH-1:0]  op_q;
   logic [LEN_WIDTH-1:0] len_q;
   logic [CYC_WIDTH-1:0] cycles_q;
   logic                 err_q;

   logic                 soft_rst;
   logic                 accept;
   logic                 zero_work;
   logic                 counting;
   logic                 cycles_max;
   logic [NUM_LANES-1:0] spurious;

   // clear_i behaves exactly like a reset, so both are folded into one term.
   assign soft_rst   = rst_i | clear_i;

   assign accept     = (state_q == ST_IDLE) && cmd_valid_i;

   // A command with no lanes or no elements skips straight to DONE so the
   // controller still sees a done pulse without any lane being disturbed.
   assign zero_work  = (lane_enable_i == '0) || (cmd_len_i == '0);

   // Any completion on a lane that is not currently pending is an error,
   // whatever the state; pending is all-zero outside WAIT.
   assign spurious   = lane_done_i & ~pending_q;

   assign counting   = (state_q == ST_LAUNCH) || (state_q == ST_WAIT);
   assign cycles_max = (cycles_q == '1);

   // State register and pending-lane bookkeeping.
   always_ff @(posedge clk_i) begin
      if (soft_rst) begin
         state_q   <= ST_IDLE;
         pending_q <= '0;
      end else begin
         state_q   <= state_d;
         pending_q <= pending_d;
      end
   end

   // Next-state logic; spurious completion bits are masked out by the AND
   // with pending so they can never retire a lane.
   always_comb begin
      state_d   = state_q;
      pending_d = pending_q;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               state_d = zero_work ? ST_DONE : ST_LAUNCH;
            end
         end
         ST_LAUNCH: begin
            pending_d = mask_q;
            state_d   = ST_WAIT;
         end
         ST_WAIT: begin
            pending_d = pending_q & ~lane_done_i;
            if (pending_d == '0) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d   = ST_IDLE;
            pending_d = '0;
         end
      endcase
   end

   // Command latch: mask, op and length are captured only on accept and held
   // until the next accepted command.
   always_ff @(posedge clk_i) begin
      if (soft_rst) begin
         mask_q <= '0;
         op_q   <= '0;
         len_q  <= '0;
      end else if (accept) begin
         mask_q <= lane_enable_i;
         op_q   <= cmd_op_i;
         len_q  <= cmd_len_i;
      end
   end

   // Operation cycle counter: zeroed on accept, counts LAUNCH and WAIT
   // cycles, saturates at all-ones and holds through DONE and IDLE.
   always_ff @(posedge clk_i) begin
      if (soft_rst) begin
         cycles_q <= '0;
      end else if (accept) begin
         cycles_q <= '0;
      end else if (counting && !cycles_max) begin
         cycles_q <= cycles_q + CYC_WIDTH'(1);
      end
   end

   // Sticky spurious-completion flag; only a reset or clear drops it.
   always_ff @(posedge clk_i) begin
      if (soft_rst) begin
         err_q <= 1'b0;
      end else if (spurious != '0) begin
         err_q <= 1'b1;
      end
   end

   // Outputs come from state and registers only, never from inputs.
   always_comb begin
      cmd_ready_o  = (state_q == ST_IDLE);
      busy_o       = (state_q != ST_IDLE);
      done_o       = (state_q == ST_DONE);
      lane_start_o = (state_q == ST_LAUNCH) ? mask_q : '0;
      lane_op_o    = op_q;
      lane_len_o   = len_q;
      cycles_o     = cycles_q;
      err_o        = err_q;
   end

endmodule

// File: tb/tb_softex_lane_sync.sv
// Self-checking bench for softex_lane_sync. Each operation is described at
// transaction level: a lane mask, a completion offset per lane (cycles after
// the accept cycle) and a set of stray completion pulses. From that the
// bench derives when done must appear, what the cycle count must be and
// when the sticky error flag must rise.

module tb_softex_lane_sync;

   localparam int NL   = 4;
   localparam int LW   = 16;
   localparam int OW   = 2;
   localparam int CW   = 4;
   localparam int CMAX = (1 << CW) - 1;
   localparam int MAXK = 64;

   logic          clk_i = 1'b0;
   logic          rst_i = 1'b0;
   logic          clear_i = 1'b0;
   logic          cmd_valid_i = 1'b0;
   logic          cmd_ready_o;
   logic [OW-1:0] cmd_op_i = '0;
   logic [LW-1:0] cmd_len_i = '0;
   logic [NL-1:0] lane_enable_i = '0;
   logic [NL-1:0] lane_start_o;
   logic [OW-1:0] lane_op_o;
   logic [LW-1:0] lane_len_o;
   logic [NL-1:0] lane_done_i = '0;
   logic          done_o;
   logic          busy_o;
   logic          err_o;
   logic [CW-1:0] cycles_o;

   int            n_checks = 0;
   int            n_errors = 0;

   int            d_arr [NL];
   logic [NL-1:0] spur_vec [MAXK];
   logic          err_exp = 1'b0;
   logic [OW-1:0] op_exp = '0;
   logic [LW-1:0] len_exp = '0;

   softex_lane_sync #(
      .NUM_LANES (NL),
      .LEN_WIDTH (LW),
      .OP_WIDTH  (OW),
      .CYC_WIDTH (CW)
   ) dut (
      .clk_i         (clk_i),
      .rst_i         (rst_i),
      .clear_i       (clear_i),
      .cmd_valid_i   (cmd_valid_i),
      .cmd_ready_o   (cmd_ready_o),
      .cmd_op_i      (cmd_op_i),
      .cmd_len_i     (cmd_len_i),
      .lane_enable_i (lane_enable_i),
      .lane_start_o  (lane_start_o),
      .lane_op_o     (lane_op_o),
      .lane_len_o    (lane_len_o),
      .lane_done_i   (lane_done_i),
      .done_o        (done_o),
      .busy_o        (busy_o),
      .err_o         (err_o),
      .cycles_o      (cycles_o)
   );

   always #5 clk_i = ~clk_i;

   initial begin
      #2000000;
      $display("FAIL watchdog observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   function automatic int imin(input int a, input int b);
      return (a < b) ? a : b;
   endfunction

   function automatic bit is_zero(input logic [NL-1:0] mask, input logic [LW-1:0] len);
      return (mask == '0) || (len == '0);
   endfunction

   // Offset of the last real completion (0 for a zero-work command).
   function automatic int last_done(input logic [NL-1:0] mask, input logic [LW-1:0] len);
      int w;
      w = 0;
      if (!is_zero(mask, len)) begin
         for (int i = 0; i < NL; i++) begin
            if (mask[i] && d_arr[i] > w) w = d_arr[i];
         end
      end
      return w;
   endfunction

   task automatic clear_stim();
      for (int i = 0; i < NL; i++) d_arr[i] = 2;
      for (int k = 0; k < MAXK; k++) spur_vec[k] = '0;
   endtask

   task automatic check_idle_outputs(input string tag);
      check_val({tag, "_ready"}, 32'(cmd_ready_o), 32'd1);
      check_val({tag, "_busy"},  32'(busy_o),      32'd0);
      check_val({tag, "_done"},  32'(done_o),      32'd0);
      check_val({tag, "_start"}, 32'(lane_start_o), 32'd0);
      check_val({tag, "_err"},   32'(err_o),       32'(err_exp));
      check_val({tag, "_op"},    32'(lane_op_o),   32'(op_exp));
      check_val({tag, "_len"},   32'(lane_len_o),  32'(len_exp));
   endtask

   // Drives one command starting in an IDLE cycle (offset 0) and checks every
   // cycle up to and including the return to IDLE.
   task automatic run_op(input logic [NL-1:0] mask, input logic [LW-1:0] len, input logic [OW-1:0] op);
      bit            zero;
      int            w;
      logic [NL-1:0] real_v;
      logic [NL-1:0] start_exp;
      zero = is_zero(mask, len);
      w    = last_done(mask, len);

      check_val("accept_ready", 32'(cmd_ready_o), 32'd1);
      check_val("accept_busy",  32'(busy_o),      32'd0);
      cmd_valid_i   = 1'b1;
      cmd_op_i      = op;
      cmd_len_i     = len;
      lane_enable_i = mask;
      lane_done_i   = spur_vec[0];
      step();
      if (spur_vec[0] != '0) err_exp = 1'b1;
      op_exp  = op;
      len_exp = len;
      cmd_valid_i   = 1'b0;
      cmd_op_i      = OW'($urandom);
      cmd_len_i     = LW'($urandom);
      lane_enable_i = NL'($urandom);

      for (int k = 1; k <= w + 1; k++) begin
         start_exp = (k == 1 && !zero) ? mask : '0;
         check_val("op_start",  32'(lane_start_o), 32'(start_exp));
         check_val("op_done",   32'(done_o),       32'(k == w + 1));
         check_val("op_busy",   32'(busy_o),       32'd1);
         check_val("op_ready",  32'(cmd_ready_o),  32'd0);
         check_val("op_lop",    32'(lane_op_o),    32'(op_exp));
         check_val("op_llen",   32'(lane_len_o),   32'(len_exp));
         check_val("op_cycles", 32'(cycles_o),     32'(imin(k - 1, CMAX)));
         check_val("op_err",    32'(err_o),        32'(err_exp));
         real_v = '0;
         if (!zero) begin
            for (int i = 0; i < NL; i++) begin
               if (mask[i] && d_arr[i] == k) real_v[i] = 1'b1;
            end
         end
         lane_done_i = (k <= w) ? (real_v | spur_vec[k]) : '0;
         step();
         if (k <= w && spur_vec[k] != '0) err_exp = 1'b1;
      end
      lane_done_i = '0;
      check_idle_outputs("op_end");
      check_val("op_end_cycles", 32'(cycles_o), 32'(imin(w, CMAX)));
   endtask

   task automatic do_clear();
      clear_i = 1'b1;
      step();
      clear_i = 1'b0;
      err_exp = 1'b0;
      op_exp  = '0;
      len_exp = '0;
      check_idle_outputs("clr");
      check_val("clr_cycles", 32'(cycles_o), 32'd0);
   endtask

   task automatic gen_random_op(output logic [NL-1:0] mask, output logic [LW-1:0] len,
                                output logic [OW-1:0] op);
      int  w;
      int  k;
      int  i;
      bit  pend;
      clear_stim();
      mask = NL'($urandom_range(0, 15));
      len  = ($urandom_range(0, 5) == 0) ? '0 : LW'($urandom_range(1, 65535));
      op   = OW'($urandom_range(0, 3));
      for (int j = 0; j < NL; j++) d_arr[j] = $urandom_range(2, 10);
      if ($urandom_range(0, 9) == 0) d_arr[$urandom_range(0, NL - 1)] = 24;
      w = last_done(mask, len);
      if ($urandom_range(0, 2) == 0) begin
         for (int a = 0; a < 8; a++) begin
            k = $urandom_range(0, w);
            i = $urandom_range(0, NL - 1);
            pend = !is_zero(mask, len) && mask[i] && (k >= 2) && (k <= d_arr[i]);
            if (!pend) begin
               spur_vec[k][i] = 1'b1;
               break;
            end
         end
      end
   endtask

   initial begin
      logic [NL-1:0] m;
      logic [LW-1:0] l;
      logic [OW-1:0] o;
      int            gap;

      // Reset held for two cycles with a command offered: no accept allowed.
      rst_i         = 1'b1;
      cmd_valid_i   = 1'b1;
      cmd_op_i      = 2'd3;
      cmd_len_i     = 16'd9;
      lane_enable_i = 4'hF;
      for (int r = 0; r < 2; r++) begin
         step();
         check_idle_outputs("rst");
         check_val("rst_cycles", 32'(cycles_o), 32'd0);
      end
      rst_i       = 1'b0;
      cmd_valid_i = 1'b0;
      step();
      check_idle_outputs("post_rst");

      // Staggered completions.
      clear_stim();
      d_arr[0] = 3; d_arr[1] = 4; d_arr[2] = 4; d_arr[3] = 7;
      run_op(4'hF, 16'd16, 2'd2);

      // All lanes complete in the first WAIT cycle.
      clear_stim();
      d_arr[0] = 2; d_arr[1] = 2; d_arr[2] = 2; d_arr[3] = 2;
      run_op(4'hF, 16'd5, 2'd1);

      // Masked lanes with a stray completion from lane 1.
      clear_stim();
      d_arr[0] = 4; d_arr[2] = 4;
      spur_vec[3] = 4'b0010;
      run_op(4'b0101, 16'd9, 2'd3);
      do_clear();

      // Zero-work commands.
      clear_stim();
      run_op(4'hF, 16'd0, 2'd1);
      clear_stim();
      run_op(4'h0, 16'd8, 2'd2);

      // Long operation exercising cycle-counter saturation.
      clear_stim();
      d_arr[0] = 24; d_arr[1] = 5; d_arr[2] = 20; d_arr[3] = 3;
      run_op(4'hF, 16'd100, 2'd0);

      // Clear while two lanes are still pending.
      clear_stim();
      cmd_valid_i   = 1'b1;
      cmd_op_i      = 2'd1;
      cmd_len_i     = 16'd7;
      lane_enable_i = 4'hF;
      step();
      cmd_valid_i   = 1'b0;
      step();
      lane_done_i   = 4'b0011;
      step();
      lane_done_i   = 4'b0000;
      clear_i       = 1'b1;
      step();
      clear_i       = 1'b0;
      op_exp        = '0;
      len_exp       = '0;
      err_exp       = 1'b0;
      check_idle_outputs("abort");
      check_val("abort_cycles", 32'(cycles_o), 32'd0);
      for (int r = 0; r < 3; r++) begin
         step();
         check_val("abort_no_done", 32'(done_o), 32'd0);
         check_val("abort_idle",    32'(busy_o), 32'd0);
      end
      lane_done_i = 4'b0100;
      step();
      lane_done_i = 4'b0000;
      err_exp     = 1'b1;
      check_val("stray_err", 32'(err_o), 32'd1);
      step();
      check_val("stray_err_hold", 32'(err_o), 32'd1);
      do_clear();

      // Randomized operations with random idle gaps between them.
      for (int n = 0; n < 40; n++) begin
         gen_random_op(m, l, o);
         run_op(m, l, o);
         gap = $urandom_range(0, 2);
         for (int g = 0; g < gap; g++) begin
            step();
            check_idle_outputs("gap");
         end
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
